// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns the fetch PC, keeps one I-cache request in flight,
// pre-decodes responses for the branch predictor and queues them in the FOQ.
// Define FETCH_RVC_EN to enable compressed (16-bit) pre-decode and 2-byte PC steps.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          FOQ_DEPTH = 8,
  parameter int          FOQ_W     = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic        branch,
  output logic [31:0] imm,
  output logic        inst_length,
  output logic [31:0] pc_out,
  output logic        foq_full,
  input  logic        need_branch,
  input  logic [31:0] branch_addr,
  input  logic        predict_fail,
  input  logic [31:0] fail_addr,
  input  logic        deq_ready,
  output logic        deq_valid,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  output logic        deq_pred
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } foq_entry_t;

  localparam logic [FOQ_W:0] DEPTH_C = (FOQ_W+1)'(FOQ_DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      drain_addr_q, drain_addr_d;
  logic [FOQ_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FOQ_W:0]   count_q, count_d;
  foq_entry_t       foq_q [FOQ_DEPTH];

  logic        is_rvc, is_br, is_jmp;
  logic [31:0] br_imm, jmp_imm, pc_step, next_pc;
  logic        push, pop;
  foq_entry_t  push_entry;

  // Pre-decode of the response word; only meaningful while a response is being pushed.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_rvc  = 1'b0;
    is_br   = (ic_resp_data[6:0] == 7'b1100011);
    is_jmp  = (ic_resp_data[6:0] == 7'b1101111);
    br_imm  = {{20{ic_resp_data[31]}}, ic_resp_data[7], ic_resp_data[30:25],
               ic_resp_data[11:8], 1'b0};
    jmp_imm = {{12{ic_resp_data[31]}}, ic_resp_data[19:12], ic_resp_data[20],
               ic_resp_data[30:21], 1'b0};
`ifdef FETCH_RVC_EN
    if (ic_resp_data[1:0] != 2'b11) begin
      is_rvc  = 1'b1;
      // Quadrant 01: funct3 110/111 are C.BEQZ/C.BNEZ, 001/101 are C.JAL/C.J.
      is_br   = (ic_resp_data[1:0] == 2'b01) && (ic_resp_data[15:14] == 2'b11);
      is_jmp  = (ic_resp_data[1:0] == 2'b01) && (ic_resp_data[14:13] == 2'b01);
      br_imm  = {{23{ic_resp_data[12]}}, ic_resp_data[12], ic_resp_data[6:5],
                 ic_resp_data[2], ic_resp_data[11:10], ic_resp_data[4:3], 1'b0};
      jmp_imm = {{20{ic_resp_data[12]}}, ic_resp_data[12], ic_resp_data[8],
                 ic_resp_data[10:9], ic_resp_data[6], ic_resp_data[7], ic_resp_data[2],
                 ic_resp_data[11], ic_resp_data[5:3], 1'b0};
    end
`endif
    pc_step = is_rvc ? 32'd2 : 32'd4;
    if (is_br && need_branch) next_pc = branch_addr;
    else if (is_jmp)          next_pc = pc_q + jmp_imm;
    else                      next_pc = pc_q + pc_step;
  end

  assign push = rdy_in && !predict_fail && (state_q == S_FETCH) && ic_resp_valid;
  assign pop  = rdy_in && !predict_fail && deq_ready && (count_q != '0);

  assign push_entry.inst = is_rvc ? {16'h0, ic_resp_data[15:0]} : ic_resp_data;
  assign push_entry.pc   = pc_q;
  assign push_entry.pred = is_br ? need_branch : is_jmp;

  assign branch       = push && is_br;
  assign imm          = !push ? 32'h0 : is_br ? br_imm : is_jmp ? jmp_imm : 32'h0;
  assign inst_length  = !is_rvc;
  assign pc_out       = push ? pc_q : 32'h0;

  assign ic_req_valid = (state_q != S_HOLD);
  assign ic_req_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign foq_full  = (count_q == DEPTH_C);
  assign deq_valid = (count_q != '0);
  assign deq_inst  = foq_q[rd_ptr_q].inst;
  assign deq_pc    = foq_q[rd_ptr_q].pc;
  assign deq_pred  = foq_q[rd_ptr_q].pred;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_q + {{FOQ_W{1'b0}}, push} - {{FOQ_W{1'b0}}, pop};
    wr_ptr_d     = push ? wr_ptr_q + FOQ_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + FOQ_W'(1) : rd_ptr_q;
    if (predict_fail) begin
      pc_d     = fail_addr;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // A request still in flight must be drained so its stale data never reaches the FOQ.
      if (state_q == S_FETCH && !ic_resp_valid) begin
        state_d      = S_DRAIN;
        drain_addr_d = pc_q;
      end else if (state_q == S_DRAIN && !ic_resp_valid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: if (ic_resp_valid) begin
          pc_d    = next_pc;
          state_d = (count_d == DEPTH_C) ? S_HOLD : S_FETCH;
        end
        S_HOLD:  if (count_d != DEPTH_C) state_d = S_FETCH;
        S_DRAIN: if (ic_resp_valid) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: FOQ storage is not reset; count_q gates every read, so contents are don't-care when empty.
  always_ff @(posedge clk_in) begin
    if (push) foq_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: a pre-decode vector table, hand-written corner
// sequences (FOQ fill, misprediction drain, freeze) and a randomized run against a queue model.
module tb_inst_fetcher;

  localparam int DEPTH = 8;
`ifdef FETCH_RVC_EN
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
`endif

  logic        clk, rst_n, rdy_in;
  logic        ic_req_valid, ic_resp_valid;
  logic [31:0] ic_req_addr, ic_resp_data;
  logic        branch, inst_length, foq_full;
  logic [31:0] imm, pc_out;
  logic        need_branch, predict_fail, deq_ready, deq_valid, deq_pred;
  logic [31:0] branch_addr, fail_addr, deq_inst, deq_pc;

  inst_fetcher dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .branch(branch), .imm(imm), .inst_length(inst_length), .pc_out(pc_out),
    .foq_full(foq_full), .need_branch(need_branch), .branch_addr(branch_addr),
    .predict_fail(predict_fail), .fail_addr(fail_addr),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_pred(deq_pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC, stale-request flag and the FOQ as a queue of entries.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  typedef struct {
    bit          four;
    bit          br;
    bit          jmp;
    logic [31:0] off;
  } dec_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  bit          m_stale;

  // Offsets assembled by weighting each encoded field, sign bit counted negative.
  function automatic dec_t decode(input logic [31:0] d);
    dec_t r;
    r.four = 1'b1;
    r.br   = (d[6:0] == 7'b1100011);
    r.jmp  = (d[6:0] == 7'b1101111);
    r.off  = 32'h0;
    if (r.br)
      r.off = 32'(int'(d[11:8]) * 2 + int'(d[30:25]) * 32 + int'(d[7]) * 2048
                  - int'(d[31]) * 4096);
    if (r.jmp)
      r.off = 32'(int'(d[30:21]) * 2 + int'(d[20]) * 2048 + int'(d[19:12]) * 4096
                  - int'(d[31]) * 1048576);
`ifdef FETCH_RVC_EN
    if (d[1:0] != 2'b11) begin
      r.four = 1'b0;
      r.br   = (d[1:0] == 2'b01) && (d[15:13] == 3'b110 || d[15:13] == 3'b111);
      r.jmp  = (d[1:0] == 2'b01) && (d[15:13] == 3'b001 || d[15:13] == 3'b101);
      r.off  = 32'h0;
      if (r.br)
        r.off = 32'(int'(d[4:3]) * 2 + int'(d[11:10]) * 8 + int'(d[2]) * 32
                    + int'(d[6:5]) * 64 - int'(d[12]) * 256);
      if (r.jmp)
        r.off = 32'(int'(d[5:3]) * 2 + int'(d[11]) * 16 + int'(d[2]) * 32 + int'(d[7]) * 64
                    + int'(d[6]) * 128 + int'(d[10:9]) * 256 + int'(d[8]) * 1024
                    - int'(d[12]) * 2048);
    end
`endif
    return r;
  endfunction

  function automatic bit model_req();
    return m_stale || (mq.size() < DEPTH);
  endfunction

  // Drive one cycle's inputs, compare every output against the model, then advance the model.
  task automatic apply(input bit rdy, input bit rv, input logic [31:0] data, input bit nb,
                       input logic [31:0] ba, input bit pf, input logic [31:0] fa, input bit dr);
    bit   exp_req, do_push;
    dec_t dc;
    ent_t e;
    rdy_in = rdy; ic_resp_valid = rv; ic_resp_data = data; need_branch = nb;
    branch_addr = ba; predict_fail = pf; fail_addr = fa; deq_ready = dr;
    #1;
    exp_req = model_req();
    check("req_valid", ic_req_valid, exp_req);
    if (exp_req) check("req_addr", ic_req_addr, m_stale ? m_stale_addr : m_pc);
    check("deq_valid", deq_valid, mq.size() > 0);
    check("foq_full", foq_full, mq.size() == DEPTH);
    if (mq.size() > 0) begin
      check("deq_inst", deq_inst, mq[0].inst);
      check("deq_pc", deq_pc, mq[0].pc);
      check("deq_pred", deq_pred, mq[0].pred);
    end
    do_push = rdy && !pf && !m_stale && exp_req && rv;
    dc = decode(data);
    check("branch", branch, do_push && dc.br);
    if (do_push) begin
      check("inst_length", inst_length, dc.four);
      check("pc_out", pc_out, m_pc);
      if (dc.br) check("imm", imm, dc.off);
    end
    if (!rv) begin
      check("idle_pc_out", pc_out, 32'h0);
      check("idle_imm", imm, 32'h0);
    end
    if (rdy) begin
      if (pf) begin
        if (exp_req && !rv) begin
          if (!m_stale) m_stale_addr = m_pc;
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
        end
        m_pc = fa;
        mq.delete();
      end else begin
        if (dr && mq.size() > 0) void'(mq.pop_front());
        if (m_stale) begin
          if (rv) m_stale = 1'b0;
        end else if (do_push) begin
          e.inst = dc.four ? data : {16'h0, data[15:0]};
          e.pc   = m_pc;
          e.pred = dc.br ? nb : dc.jmp;
          mq.push_back(e);
          if (dc.br && nb) m_pc = ba;
          else if (dc.jmp) m_pc = m_pc + dc.off;
          else             m_pc = m_pc + (dc.four ? 32'd4 : 32'd2);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0013;
      1:       return {r[31:7], 7'b1100011};
      2:       return {r[31:7], 7'b1101111};
      3:       return {r[31:2], 2'b11};
      4:       return {r[31:2], 2'b01};
      default: return r;
    endcase
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          nb;
    bit          exp_br;
    logic [31:0] exp_imm;
    bit          exp_len;
    logic [31:0] exp_off;
  } vec_t;

  initial begin : main
    vec_t        vt[$];
    logic [31:0] pc0, saved;

    vt.push_back('{32'h0000_0013, 1'b0, 1'b0, 32'h0,         1'b1, 32'd4});
    vt.push_back('{32'h0000_0013, 1'b0, 1'b0, 32'h0,         1'b1, 32'd4});
    vt.push_back('{32'hFE00_0EE3, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC});
    vt.push_back('{32'h0020_8463, 1'b0, 1'b1, 32'd8,         1'b1, 32'd4});
    vt.push_back('{32'h0080_00EF, 1'b0, 1'b0, 32'h0,         1'b1, 32'd8});
    vt.push_back('{32'h0000_1063, 1'b1, 1'b1, 32'h0,         1'b1, 32'h0});
    vt.push_back('{32'h8000_0063, 1'b0, 1'b1, 32'hFFFF_F000, 1'b1, 32'd4});
`ifdef FETCH_RVC_EN
    vt.push_back('{32'h0000_C111, 1'b0, 1'b1, 32'd4,         1'b0, 32'd2});
    vt.push_back('{32'h0000_A001, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0});
    vt.push_back('{32'h0000_0001, 1'b0, 1'b0, 32'h0,         1'b0, 32'd2});
`else
    vt.push_back('{32'h0000_C111, 1'b0, 1'b0, 32'h0,         1'b1, 32'd4});
`endif

    m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
    rst_n = 1'b0; rdy_in = 1'b1; ic_resp_valid = 1'b0; ic_resp_data = 32'h0;
    need_branch = 1'b0; branch_addr = 32'h0; predict_fail = 1'b0; fail_addr = 32'h0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state with no response in flight.
    apply(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    tick();

    // Pre-decode vector table; deq_ready held high so the FOQ never fills.
    foreach (vt[i]) begin
      pc0 = m_pc;
      apply(1, 1, vt[i].data, vt[i].nb, pc0 + vt[i].exp_off, 0, 32'h0, 1);
      check($sformatf("tbl%0d_branch", i), branch, vt[i].exp_br);
      check($sformatf("tbl%0d_len", i), inst_length, vt[i].exp_len);
      if (vt[i].exp_br) check($sformatf("tbl%0d_imm", i), imm, vt[i].exp_imm);
      tick();
      check($sformatf("tbl%0d_next", i), ic_req_addr, pc0 + vt[i].exp_off);
    end

    // Fill the FOQ with the decoder stalled, then release one slot.
    for (int i = 0; i < 20; i++) begin
      apply(1, model_req(), 32'h0000_0013, 0, 32'h0, 0, 32'h0, 0);
      tick();
    end
    check("fill_full", foq_full, 1'b1);
    check("fill_no_req", ic_req_valid, 1'b0);
    apply(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    check("resume_req", ic_req_valid, 1'b1);

    // Misprediction with a request in flight: drain, drop, then refetch at fail_addr.
    saved = m_pc;
    apply(1, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0);
    tick();
    check("drain_addr", ic_req_addr, saved);
    check("flush_empty", deq_valid, 1'b0);
    apply(1, 1, 32'hFE00_0EE3, 1, 32'h0, 0, 32'h0, 0);
    check("drop_branch", branch, 1'b0);
    tick();
    check("redirect_addr", ic_req_addr, 32'h40);
    check("drop_empty", deq_valid, 1'b0);
    apply(1, 1, 32'h0000_0013, 0, 32'h0, 0, 32'h0, 0);
    tick();
    check("refetch_pc", deq_pc, 32'h40);

    // rdy_in low freezes everything, including a misprediction.
    saved = m_pc;
    apply(0, 0, 32'h0, 0, 32'h0, 1, 32'h80, 1);
    tick();
    check("freeze_addr", ic_req_addr, saved);
    check("freeze_foq", deq_valid, 1'b1);

    // Randomized traffic with alternating light/heavy decoder back-pressure.
    for (int i = 0; i < 4000; i++) begin
      bit rdy, rv, pf, dr;
      rdy = ($urandom_range(0, 9) != 0);
      rv  = rdy && model_req() && ($urandom_range(0, 2) == 0);
      pf  = rdy && ($urandom_range(0, 24) == 0);
      dr  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      apply(rdy, rv, gen_inst(), ($urandom_range(0, 1) == 1), $urandom & ALIGN_MASK,
            pf, $urandom & ALIGN_MASK, dr);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
